// File: rtl/adder_pipe_pkg.sv
// Shared types and defaults for the adder_pipe block.
// Optional accumulator ops are enabled with the ADDER_PIPE_ACC_EN macro.
package adder_pipe_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ACC  = 2'd2,
    OP_LOAD = 2'd3
  } op_e;

  typedef logic [WIDTH_DEF:0] result_t;

endpackage

// File: rtl/add_if.sv
// Source/sink bundle between the stimulus agent, adder_pipe and the consumer.
// The driver modport feeds operands and takes results; dut mirrors it.
interface add_if
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic clk,
  input logic rst
);

  logic                         s_valid;
  logic                         s_ready;
  logic [WIDTH-1:0]             s_a;
  logic [WIDTH-1:0]             s_b;
  logic [1:0]                   s_op;
  logic                         m_valid;
  logic                         m_ready;
  logic [WIDTH:0]               m_c;
  logic [$clog2(DEPTH+1)-1:0]   level;

  modport driver (
    input  clk, rst, s_ready, m_valid, m_c, level,
    output s_valid, s_a, s_b, s_op, m_ready
  );

  modport dut (
    input  clk, rst, s_valid, s_a, s_b, s_op, m_ready,
    output s_ready, m_valid, m_c, level
  );

  modport mon (
    input clk, rst, s_valid, s_ready, s_a, s_b, s_op,
          m_valid, m_ready, m_c, level
  );

endinterface

// File: rtl/adder_pipe_fifo.sv
// Synchronous FIFO with occupancy counter and wrapping pointers.
// The head output holds the last popped value while the FIFO is empty.
module adder_pipe_fifo
  import adder_pipe_pkg::*;
#(
  parameter  int W     = WIDTH_DEF + 1,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hold_q, hold_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign level_o = cnt_q;
  assign data_o  = empty_o ? hold_q : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    hold_d   = do_pop  ? mem_q[rd_ptr_q]   : hold_q;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Handshaked add/sub unit writing results into an output FIFO.
// Define ADDER_PIPE_ACC_EN to add the accumulate (10) and load (11) ops.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_a,
  input  logic [WIDTH-1:0] s_b,
  input  logic [1:0]       s_op,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH:0]   m_c,
  output logic [LW-1:0]    level
);

  logic           full, empty;
  logic           accept, pop;
  logic [WIDTH:0] res_d;

  function automatic logic [WIDTH:0] arith(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic             sub);
    return sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
  endfunction

  // Flops are held in reset while rst is high, so accept need not see rst.
  assign s_ready = !rst && !full;
  assign accept  = s_valid && !full;
  assign m_valid = !empty;
  assign pop     = m_valid && m_ready;

`ifdef ADDER_PIPE_ACC_EN
  logic [WIDTH:0] acc_q, acc_d;

  always_comb begin
    res_d = '0;
    case (op_e'(s_op))
      OP_ADD:  res_d = arith(s_a, s_b, 1'b0);
      OP_SUB:  res_d = arith(s_a, s_b, 1'b1);
      OP_ACC:  res_d = acc_q + {1'b0, s_a};
      default: res_d = {1'b0, s_a};
    endcase
    acc_d = (accept && s_op[1]) ? res_d : acc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  // Without the accumulator, the high op bit folds onto add/sub.
  always_comb begin
    res_d = '0;
    case (op_e'(s_op))
      OP_ADD, OP_ACC: res_d = arith(s_a, s_b, 1'b0);
      default:        res_d = arith(s_a, s_b, 1'b1);
    endcase
  end
`endif

  adder_pipe_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (pop),
    .data_i  (res_d),
    .data_o  (m_c),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule
